// File: rtl/broadcast_pkg.sv
// -----------------------------------------------------------------------------
// broadcast_pkg
// Shared constants for the broadcast fan-out block and its per-channel lane.
// Holds the default geometry that the top module and the lane sub-module both
// use, so the two files cannot drift apart.
// -----------------------------------------------------------------------------
package broadcast_pkg;

    // Default data width of the argument word and of each result lane.
    localparam int DEFAULT_WIDTH = 16;

    // Default number of independent result channels.
    localparam int DEFAULT_DEPTH = 2;

endpackage : broadcast_pkg

// File: rtl/broadcast_lane.sv
// -----------------------------------------------------------------------------
// broadcast_lane
// One result channel of the broadcast block. It owns this channel's pending
// flop and presents the shared held word on its own lane.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   i_accept   in   the top is loading a new word this cycle
//   i_res_rdy  in   this channel's consumer is ready
//   i_hold     in   the word currently held by the top (WIDTH bits)
//   o_res_stb  out  this channel still has to take the held word
//   o_res_dat  out  this channel's lane, always equal to i_hold
// -----------------------------------------------------------------------------
module broadcast_lane
    import broadcast_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_accept,
    input  logic             i_res_rdy,
    input  logic [WIDTH-1:0] i_hold,
    output logic             o_res_stb,
    output logic [WIDTH-1:0] o_res_dat
);

    logic r_pend;
    logic w_take;

    // A ready without a pending word is a no-op, so the take is qualified.
    assign w_take = r_pend & i_res_rdy;

    // Accept is checked before take: when the final take and a new accept land
    // on the same edge, the channel must arm for the new word, not clear.
    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
        end else if (i_accept) begin
            r_pend <= 1'b1;
        end else if (w_take) begin
            r_pend <= 1'b0;
        end
    end

    assign o_res_stb = r_pend;
    assign o_res_dat = i_hold;

endmodule : broadcast_lane

// File: rtl/broadcast.sv
// -----------------------------------------------------------------------------
// broadcast
// Single-stream to multi-stream fan-out. One argument word is accepted over a
// strobe/ready handshake, held in a register, and offered to DEPTH independent
// result channels. The word is released only after every channel has taken it;
// each channel sees every word exactly once.
//
// Configuration macro: BROADCAST_PIPE_EN
//   undefined (default): o_arg_rdy = no channel pending; fully registered, one
//                        bubble cycle between words.
//   defined:             o_arg_rdy also rises in the cycle of the final take(s),
//                        allowing one word per cycle; this adds a combinational
//                        path from i_res_rdy to o_arg_rdy.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   i_arg_stb  in   argument word valid
//   i_arg_dat  in   argument word (WIDTH bits)
//   o_arg_rdy  out  block can accept a word
//   o_res_stb  out  per-channel result valid, bit n is channel n (DEPTH bits)
//   o_res_dat  out  lane n is [n*WIDTH +: WIDTH], every lane carries the held word
//   i_res_rdy  in   per-channel consumer ready (DEPTH bits)
// -----------------------------------------------------------------------------
module broadcast
    import broadcast_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_arg_stb,
    input  logic [WIDTH-1:0]       i_arg_dat,
    output logic                   o_arg_rdy,
    output logic [DEPTH-1:0]       o_res_stb,
    output logic [DEPTH*WIDTH-1:0] o_res_dat,
    input  logic [DEPTH-1:0]       i_res_rdy
);

    logic [WIDTH-1:0] r_hold;
    logic [DEPTH-1:0] w_pend;
    logic             w_accept;

`ifdef BROADCAST_PIPE_EN
    // Ready as soon as every still-pending channel is taking this cycle.
    logic [DEPTH-1:0] w_take;
    assign w_take    = w_pend & i_res_rdy;
    assign o_arg_rdy = ((w_pend & ~w_take) == '0);
`else
    // Purely registered: ready only once the pending mask has drained.
    assign o_arg_rdy = (w_pend == '0);
`endif

    assign w_accept = i_arg_stb & o_arg_rdy;

    // NOTE: the holding register is reset even though it is data, because a
    // zero res_dat out of reset is part of the block's visible contract.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_accept) begin
            r_hold <= i_arg_dat;
        end
    end

    for (genvar n = 0; n < DEPTH; n++) begin : g_lane
        broadcast_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_accept  (w_accept),
            .i_res_rdy (i_res_rdy[n]),
            .i_hold    (r_hold),
            .o_res_stb (w_pend[n]),
            .o_res_dat (o_res_dat[n*WIDTH +: WIDTH])
        );
    end

    assign o_res_stb = w_pend;

endmodule : broadcast

// File: tb/tb_broadcast.sv
// -----------------------------------------------------------------------------
// tb_broadcast
// Directed self-checking bench for broadcast with WIDTH=16, DEPTH=2. Inputs are
// driven 1 time unit after the rising edge and outputs are sampled 1 unit after
// that, well away from the active edge. Expectations that differ with
// BROADCAST_PIPE_EN are selected by the same macro.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_broadcast;

    logic        clk = 1'b0;
    logic        rst;
    logic        arg_stb;
    logic [15:0] arg_dat;
    logic        arg_rdy;
    logic [1:0]  res_stb;
    logic [31:0] res_dat;
    logic [1:0]  res_rdy;

    int n_checks = 0;
    int n_errors = 0;

`ifdef BROADCAST_PIPE_EN
    localparam int EXP_GAP = 1;
`else
    localparam int EXP_GAP = 2;
`endif

    always #5 clk = ~clk;

    broadcast #(
        .WIDTH (16),
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_arg_stb (arg_stb),
        .i_arg_dat (arg_dat),
        .o_arg_rdy (arg_rdy),
        .o_res_stb (res_stb),
        .o_res_dat (res_dat),
        .i_res_rdy (res_rdy)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case something below never returns.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] words [3];
        logic [15:0] q0 [$];
        logic [15:0] q1 [$];
        int          t0 [$];
        int          k;
        int          cyc;
        int          bad;
        int          low_cnt;
        logic        acc;

        words = '{16'h0001, 16'h0002, 16'h0003};

        // ---- 1: reset state, then first accept ----
        rst = 1'b1; arg_stb = 1'b0; arg_dat = '0; res_rdy = '0;
        step(); step();
        rst = 1'b0;
        #1;
        check("s1_rst_stb", res_stb, 2'b00);
        check("s1_rst_rdy", arg_rdy, 1'b1);
        check("s1_rst_dat", res_dat, 32'h0);
        arg_stb = 1'b1; arg_dat = 16'hA5A5;
        step();
        arg_stb = 1'b0; arg_dat = 16'hFFFF;
        #1;
        check("s1_stb", res_stb, 2'b11);
        check("s1_dat", res_dat, 32'hA5A5_A5A5);
        check("s1_rdy_full", arg_rdy, 1'b0);

        // drain
        res_rdy = 2'b11;
        step();
        res_rdy = 2'b00;
        #1;
        check("s1_drained_stb", res_stb, 2'b00);
        check("s1_drained_rdy", arg_rdy, 1'b1);

        // ---- 2: staggered takes ----
        arg_stb = 1'b1; arg_dat = 16'h1234;
        step();                              // edge t: accept
        arg_stb = 1'b0; res_rdy = 2'b01;     // t+1
        #1;
        check("s2_t1_stb", res_stb, 2'b11);
        check("s2_t1_dat", res_dat, 32'h1234_1234);
        check("s2_t1_rdy", arg_rdy, 1'b0);
        step();
        res_rdy = 2'b01;                     // t+2, ready on a channel already taken
        #1;
        check("s2_t2_stb", res_stb, 2'b10);
        check("s2_t2_rdy", arg_rdy, 1'b0);
        step();
        res_rdy = 2'b10;                     // t+3
        #1;
        check("s2_t3_stb", res_stb, 2'b10);
`ifdef BROADCAST_PIPE_EN
        check("s2_t3_rdy", arg_rdy, 1'b1);
`else
        check("s2_t3_rdy", arg_rdy, 1'b0);
`endif
        step();
        res_rdy = 2'b00;                     // t+4
        #1;
        check("s2_t4_stb", res_stb, 2'b00);
        check("s2_t4_rdy", arg_rdy, 1'b1);

        // ---- 3: streaming three words, all channels ready ----
        res_rdy = 2'b11;
        k = 0; cyc = 0; low_cnt = 0;
        while ((q0.size() < 3 || q1.size() < 3) && cyc < 30) begin
            arg_stb = (k < 3);
            arg_dat = (k < 3) ? words[k] : 16'h0;
            #1;
            if (res_stb[0]) begin
                q0.push_back(res_dat[15:0]);
                t0.push_back(cyc);
            end
            if (res_stb[1]) q1.push_back(res_dat[31:16]);
            if (k > 0 && k < 3 && !arg_rdy) low_cnt++;
            acc = arg_stb && arg_rdy;
            step();
            if (acc) k++;
            cyc++;
        end
        arg_stb = 1'b0; res_rdy = 2'b00;
        check("s3_bound", (cyc < 30), 1'b1);
        check("s3_cnt0", q0.size(), 3);
        check("s3_cnt1", q1.size(), 3);
        for (int i = 0; i < 3 && i < q0.size(); i++) check($sformatf("s3_ch0_w%0d", i), q0[i], words[i]);
        for (int i = 0; i < 3 && i < q1.size(); i++) check($sformatf("s3_ch1_w%0d", i), q1[i], words[i]);
        if (t0.size() == 3) begin
            check("s3_gap01", t0[1] - t0[0], EXP_GAP);
            check("s3_gap12", t0[2] - t0[1], EXP_GAP);
        end
`ifdef BROADCAST_PIPE_EN
        check("s3_rdy_held", low_cnt, 0);
`endif

        // ---- 4: channel 1 stalled with a new word pending ----
        arg_stb = 1'b1; arg_dat = 16'h1111; res_rdy = 2'b01;
        #1;
        check("s4_first_rdy", arg_rdy, 1'b1);
        step();
        arg_dat = 16'hBEEF;                  // keep strobing the next word
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (arg_rdy !== 1'b0 || res_dat[31:16] !== 16'h1111) bad++;
            step();
        end
        #1;
        check("s4_stall_bad", bad, 0);
        check("s4_stall_stb", res_stb, 2'b10);
        check("s4_stall_hold", res_dat, 32'h1111_1111);
        res_rdy = 2'b11;
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) begin
            #1;
            acc = arg_rdy;
            step();
        end
        arg_stb = 1'b0; res_rdy = 2'b00;
        #1;
        check("s4_accept_bound", acc, 1'b1);
        check("s4_new_stb", res_stb, 2'b11);
        check("s4_new_dat", res_dat, 32'hBEEF_BEEF);
        res_rdy = 2'b11;
        step();
        res_rdy = 2'b00;

        // ---- 5: reset while FULL, channel 0 already taken ----
        arg_stb = 1'b1; arg_dat = 16'h5555;
        step();
        arg_stb = 1'b0; res_rdy = 2'b01;
        step();
        res_rdy = 2'b00;
        #1;
        check("s5_pre_stb", res_stb, 2'b10);
        check("s5_pre_dat", res_dat[31:16], 16'h5555);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("s5_rst_stb", res_stb, 2'b00);
        check("s5_rst_rdy", arg_rdy, 1'b1);
        check("s5_rst_dat", res_dat, 32'h0);
        res_rdy = 2'b10;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (res_stb[1]) bad++;
            step();
        end
        res_rdy = 2'b00;
        check("s5_no_late", bad, 0);

        // ---- 6: reset beats accept ----
        rst = 1'b1; arg_stb = 1'b1; arg_dat = 16'h7777;
        step();
        rst = 1'b0; arg_stb = 1'b0;
        #1;
        check("s6_stb", res_stb, 2'b00);
        check("s6_dat", res_dat, 32'h0);
        check("s6_rdy", arg_rdy, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_broadcast
